// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants for the 8-way round-robin arbiter and its downstream 3-to-8 decoder.
package rr_arbiter_8_pkg;

  localparam int unsigned NUM_REQ  = 8;
  localparam int unsigned IDX_W    = 3;
  // Decoder input width; the decoder bench imports this to stay in step with gnt_idx.
  localparam int unsigned DEC_IN_W = IDX_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the clients (master) and the arbiter (slave).
interface rr_arbiter_8_if;
  import rr_arbiter_8_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               timeout;

  modport master (
    output req, done,
    input  gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt_idx, gnt_valid, timeout
  );

endinterface

// File: rtl/rr_prio_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping mod 8.
module rr_prio_pick
  import rr_arbiter_8_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_any
);

  logic [NUM_REQ-1:0] w_rot;
  logic [IDX_W-1:0]   w_off;

  always_comb begin
    // Rotate so that bit 0 is the highest-priority requester.
    w_rot = (i_req >> i_ptr) | (i_req << (NUM_REQ - i_ptr));
    w_off = '0;
    // Scan from the top so the lowest set bit is the last (winning) assignment.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_rot[NUM_REQ-1-i]) begin
        w_off = IDX_W'(NUM_REQ - 1 - i);
      end
    end
    o_winner = i_ptr + w_off;
    o_any    = |i_req;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with locked grants, done release and MAX_HOLD forced release.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter_8_if.slave bus
);

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_gnt_idx;
  logic             r_gnt_valid;
  logic             r_timeout;
  logic [CNT_W-1:0] r_hold_cnt;

  logic [IDX_W-1:0] w_winner;
  logic             w_any;

  rr_prio_pick u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_hold_cnt  <= '0;
    end else begin
      r_timeout <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_any) begin
          r_gnt_idx   <= w_winner;
          r_gnt_valid <= 1'b1;
          r_hold_cnt  <= CNT_W'(1);
          r_state     <= ST_GRANT;
        end
      end else begin
        // done takes precedence over the hold limit, so a coincident done never pulses timeout.
        if (bus.done || (r_hold_cnt == CNT_W'(MAX_HOLD))) begin
          r_gnt_valid <= 1'b0;
          r_ptr       <= idx_inc(r_gnt_idx);
          r_hold_cnt  <= '0;
          r_state     <= ST_IDLE;
          r_timeout   <= ~bus.done;
        end else begin
          r_hold_cnt <= r_hold_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 (MAX_HOLD=4 main instance, default-parameter hold check) and rr_prio_pick.
module tb_rr_arbiter_8;

  logic clk;
  logic rst;
  logic rst2;
  int   checks;
  int   failures;

  rr_arbiter_8_if u_if ();
  rr_arbiter_8_if u_if2 ();

  rr_arbiter_8 #(.MAX_HOLD(4), .CNT_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  rr_arbiter_8 u_dut16 (
    .clk (clk),
    .rst (rst2),
    .bus (u_if2.slave)
  );

  logic [7:0] p_req;
  logic [2:0] p_ptr;
  logic [2:0] p_winner;
  logic       p_any;

  rr_prio_pick u_pick (
    .i_req    (p_req),
    .i_ptr    (p_ptr),
    .o_winner (p_winner),
    .o_any    (p_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       exp_valid;
    logic [2:0] exp_idx;
    logic       exp_to;
  } vec_t;

  typedef struct {
    logic [7:0] req;
    logic [2:0] ptr;
    logic [2:0] winner;
    logic       any;
  } pick_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [2:0] idx, input logic to);
    chk({nm, ".gnt_valid"}, 32'(u_if.gnt_valid), 32'(v));
    chk({nm, ".gnt_idx"},   32'(u_if.gnt_idx),   32'(idx));
    chk({nm, ".timeout"},   32'(u_if.timeout),   32'(to));
  endtask

  vec_t  vecs[$];
  pick_t picks[$];

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    rst2     = 1'b1;
    u_if.req   = '0;
    u_if.done  = 1'b0;
    u_if2.req  = '0;
    u_if2.done = 1'b0;

    // Picker alone: {req, ptr, winner, any}
    picks.push_back('{8'h01, 3'd0, 3'd0, 1'b1});
    picks.push_back('{8'h80, 3'd0, 3'd7, 1'b1});
    picks.push_back('{8'hFF, 3'd3, 3'd3, 1'b1});
    picks.push_back('{8'h05, 3'd6, 3'd0, 1'b1});
    picks.push_back('{8'h05, 3'd1, 3'd2, 1'b1});
    picks.push_back('{8'h81, 3'd1, 3'd7, 1'b1});
    picks.push_back('{8'h22, 3'd6, 3'd1, 1'b1});
    picks.push_back('{8'h10, 3'd5, 3'd4, 1'b1});
    picks.push_back('{8'h00, 3'd4, 3'd0, 1'b0});

    // Arbiter: inputs applied before an edge, outputs expected after it.
    // Reset with all requesting, then idle with done ignored.
    vecs.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0});
    // Single requester 5: grant, done, one idle cycle, regrant.
    vecs.push_back('{1'b0, 8'h20, 1'b0, 1'b1, 3'd5, 1'b0});
    vecs.push_back('{1'b0, 8'h20, 1'b0, 1'b1, 3'd5, 1'b0});
    vecs.push_back('{1'b0, 8'h20, 1'b1, 1'b0, 3'd5, 1'b0});
    vecs.push_back('{1'b0, 8'h20, 1'b0, 1'b1, 3'd5, 1'b0});
    vecs.push_back('{1'b0, 8'h20, 1'b1, 1'b0, 3'd5, 1'b0});
    // ptr=6, req=0000_0101: wrap to 0 (locked while req[0] drops), then 2.
    vecs.push_back('{1'b0, 8'h05, 1'b0, 1'b1, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'h04, 1'b0, 1'b1, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'h04, 1'b0, 1'b1, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'h04, 1'b1, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'h05, 1'b0, 1'b1, 3'd2, 1'b0});
    vecs.push_back('{1'b0, 8'h05, 1'b1, 1'b0, 3'd2, 1'b0});
    // Requester 3 never signals done: 4 valid cycles, timeout pulse, regrant.
    vecs.push_back('{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0});
    vecs.push_back('{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0});
    vecs.push_back('{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0});
    vecs.push_back('{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0});
    vecs.push_back('{1'b0, 8'h08, 1'b0, 1'b0, 3'd3, 1'b1});
    vecs.push_back('{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0});
    vecs.push_back('{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0});
    vecs.push_back('{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0});
    vecs.push_back('{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0});
    // done coincident with the hold limit: released without timeout.
    vecs.push_back('{1'b0, 8'h08, 1'b1, 1'b0, 3'd3, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 1'b0});
    vecs.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0});

    foreach (picks[i]) begin
      p_req = picks[i].req;
      p_ptr = picks[i].ptr;
      #1;
      chk($sformatf("pick%0d.any", i), 32'(p_any), 32'(picks[i].any));
      if (picks[i].any) chk($sformatf("pick%0d.winner", i), 32'(p_winner), 32'(picks[i].winner));
    end

    foreach (vecs[i]) begin
      rst       = vecs[i].rst;
      u_if.req  = vecs[i].req;
      u_if.done = vecs[i].done;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_idx, vecs[i].exp_to);
    end

    // Fairness: all requesting, done held high; grants 0..7,0 with one idle cycle between.
    rst       = 1'b0;
    u_if.req  = 8'hFF;
    u_if.done = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      step();
      if (k % 2 == 0) chk_out($sformatf("rr%0d", k), 1'b1, 3'((k / 2) % 8), 1'b0);
      else            chk_out($sformatf("rr%0d", k), 1'b0, 3'(((k - 1) / 2) % 8), 1'b0);
    end

    // Mid-grant reset on requester 6, then ptr must be back at 0.
    u_if.req = 8'h40;
    step();
    chk_out("mr_rel", 1'b0, 3'd0, 1'b0);
    u_if.done = 1'b0;
    step();
    chk_out("mr_gnt6", 1'b1, 3'd6, 1'b0);
    rst = 1'b1;
    step();
    chk_out("mr_rst", 1'b0, 3'd0, 1'b0);
    rst      = 1'b0;
    u_if.req = 8'hC1;
    step();
    chk_out("mr_after", 1'b1, 3'd0, 1'b0);

    // Default MAX_HOLD=16 instance: count valid cycles up to the forced release.
    begin
      int cnt;
      cnt = 0;
      step();
      rst2      = 1'b0;
      u_if2.req = 8'h02;
      for (int k = 0; k < 40; k++) begin
        step();
        if (u_if2.gnt_valid) cnt++;
        else if (cnt > 0) break;
      end
      chk("hold16.cycles", 32'(cnt), 32'd16);
      chk("hold16.timeout", 32'(u_if2.timeout), 32'd1);
      chk("hold16.valid_gap", 32'(u_if2.gnt_valid), 32'd0);
      chk("hold16.idx", 32'(u_if2.gnt_idx), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
